// File: rtl/delta3_collector_if.sv
// Bundles the producer, consumer and status signals of the delta3 collector.
// The master side drives the sample stream and read requests; the slave side is the collector.
interface delta3_collector_if #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 2,
  parameter int CWIDTH = 16
);
  logic                     in_valid;
  logic signed [DWIDTH-1:0] delta3_in;
  logic signed [DWIDTH-1:0] cost_in;
  logic                     rd_en;
  logic        [AWIDTH-1:0] rd_addr;
  logic                     rd_done;
  logic                     clr_epoch;
  logic                     full;
  logic signed [DWIDTH-1:0] delta3_out;
  logic                     rd_valid;
  logic signed [DWIDTH-1:0] sample_cost;
  logic signed [DWIDTH-1:0] epoch_cost;
  logic        [CWIDTH-1:0] sample_cnt;
  logic                     sat;
  logic                     drop;

  modport master (
    output in_valid, delta3_in, cost_in, rd_en, rd_addr, rd_done, clr_epoch,
    input  full, delta3_out, rd_valid, sample_cost, epoch_cost, sample_cnt, sat, drop
  );

  modport slave (
    input  in_valid, delta3_in, cost_in, rd_en, rd_addr, rd_done, clr_epoch,
    output full, delta3_out, rd_valid, sample_cost, epoch_cost, sample_cnt, sat, drop
  );
endinterface

// File: rtl/delta3_collector.sv
// Output-layer error buffer: collects one delta3/cost pair per output neuron, holds the
// completed delta3 vector for the delta2 stage and keeps per-sample and per-epoch cost sums.
module delta3_collector #(
  parameter int DWIDTH = 32,
  parameter int x      = 4,
  parameter int AWIDTH = 2,
  parameter int CWIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  delta3_collector_if.slave  bus
);
  localparam int DEPTH = 2 ** AWIDTH;
  localparam logic signed [DWIDTH-1:0] SMAX = {1'b0, {(DWIDTH-1){1'b1}}};
  localparam logic [AWIDTH-1:0] LAST = AWIDTH'(x - 1);
  localparam logic [AWIDTH:0]   X_L  = (AWIDTH+1)'(x);

  typedef enum logic {COLLECT, FULL} state_t;

  state_t                   state_q, state_d;
  logic        [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic signed [DWIDTH-1:0] acc_q, acc_d;
  logic signed [DWIDTH-1:0] sample_cost_q, sample_cost_d;
  logic signed [DWIDTH-1:0] epoch_cost_q, epoch_cost_d;
  logic        [CWIDTH-1:0] sample_cnt_q, sample_cnt_d;
  logic                     sat_q, sat_d;
  logic                     drop_q, drop_d;
  logic                     rd_valid_q, rd_valid_d;
  logic signed [DWIDTH-1:0] delta3_out_q, delta3_out_d;
  logic signed [DWIDTH-1:0] rf_q [DEPTH];
  logic signed [DWIDTH-1:0] rf_d [DEPTH];
  logic                     wr_en;
  logic                     sample_done;
  logic        [DWIDTH:0]   acc_sum;
  logic        [DWIDTH:0]   epoch_sum;

  // Returns {overflow, value}; only the positive side clamps, negative costs sum as signed.
  function automatic logic [DWIDTH:0] sat_add(input logic signed [DWIDTH-1:0] a,
                                              input logic signed [DWIDTH-1:0] b);
    logic signed [DWIDTH:0] s;
    s = {a[DWIDTH-1], a} + {b[DWIDTH-1], b};
    if (s > $signed({1'b0, SMAX})) return {1'b1, SMAX};
    return {1'b0, s[DWIDTH-1:0]};
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_rf
      assign rf_d[gi] = (wr_en && wr_ptr_q == AWIDTH'(gi)) ? bus.delta3_in : rf_q[gi];
    end
  endgenerate

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    acc_d         = acc_q;
    sample_cost_d = sample_cost_q;
    epoch_cost_d  = epoch_cost_q;
    sample_cnt_d  = sample_cnt_q;
    sat_d         = sat_q;
    drop_d        = drop_q;
    rd_valid_d    = bus.rd_en;
    delta3_out_d  = delta3_out_q;
    wr_en         = 1'b0;
    sample_done   = 1'b0;
    acc_sum       = sat_add(acc_q, bus.cost_in);
    epoch_sum     = sat_add(epoch_cost_q, acc_sum[DWIDTH-1:0]);

    case (state_q)
      COLLECT: begin
        if (bus.in_valid) begin
          wr_en    = 1'b1;
          acc_d    = acc_sum[DWIDTH-1:0];
          wr_ptr_d = wr_ptr_q + AWIDTH'(1);
          if (acc_sum[DWIDTH]) sat_d = 1'b1;
          if (wr_ptr_q == LAST) begin
            sample_done   = 1'b1;
            state_d       = FULL;
            sample_cost_d = acc_sum[DWIDTH-1:0];
            epoch_cost_d  = epoch_sum[DWIDTH-1:0];
            if (epoch_sum[DWIDTH]) sat_d = 1'b1;
            sample_cnt_d  = sample_cnt_q + CWIDTH'(1);
            acc_d         = '0;
            wr_ptr_d      = '0;
          end
        end
      end
      FULL: begin
        if (bus.in_valid) drop_d = 1'b1;
        if (bus.rd_done)  state_d = COLLECT;
      end
      default: state_d = COLLECT;
    endcase

    // An epoch clear coinciding with a completed sample restarts the epoch at that sample.
    if (bus.clr_epoch) begin
      sat_d        = 1'b0;
      drop_d       = 1'b0;
      epoch_cost_d = sample_done ? acc_sum[DWIDTH-1:0] : '0;
      sample_cnt_d = sample_done ? CWIDTH'(1) : '0;
    end

    if (bus.rd_en) begin
      delta3_out_d = ({1'b0, bus.rd_addr} < X_L) ? rf_q[bus.rd_addr] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= COLLECT;
      wr_ptr_q      <= '0;
      acc_q         <= '0;
      sample_cost_q <= '0;
      epoch_cost_q  <= '0;
      sample_cnt_q  <= '0;
      sat_q         <= 1'b0;
      drop_q        <= 1'b0;
      rd_valid_q    <= 1'b0;
      delta3_out_q  <= '0;
      for (int i = 0; i < DEPTH; i++) rf_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      acc_q         <= acc_d;
      sample_cost_q <= sample_cost_d;
      epoch_cost_q  <= epoch_cost_d;
      sample_cnt_q  <= sample_cnt_d;
      sat_q         <= sat_d;
      drop_q        <= drop_d;
      rd_valid_q    <= rd_valid_d;
      delta3_out_q  <= delta3_out_d;
      for (int i = 0; i < DEPTH; i++) rf_q[i] <= rf_d[i];
    end
  end

  assign bus.full        = (state_q == FULL);
  assign bus.delta3_out  = delta3_out_q;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.sample_cost = sample_cost_q;
  assign bus.epoch_cost  = epoch_cost_q;
  assign bus.sample_cnt  = sample_cnt_q;
  assign bus.sat         = sat_q;
  assign bus.drop        = drop_q;
endmodule

// File: tb/tb_delta3_collector.sv
// Directed bench for delta3_collector: read results are scoreboarded through a queue,
// status outputs are checked against constants derived from the stimulus.
module tb_delta3_collector;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  delta3_collector_if #(.DWIDTH(32), .AWIDTH(2), .CWIDTH(16)) bus ();

  delta3_collector #(.DWIDTH(32), .x(4), .AWIDTH(2), .CWIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [1:0] addr, input logic [31:0] exp);
    bus.rd_en   = 1'b1;
    bus.rd_addr = addr;
    exp_q.push_back(exp);
  endtask

  task automatic beat(input logic [31:0] d, input logic [31:0] c);
    bus.in_valid  = 1'b1;
    bus.delta3_in = d;
    bus.cost_in   = c;
  endtask

  // One clock: checks rd_valid against the request just issued and pops read expectations.
  task automatic step();
    logic pend;
    logic [31:0] e;
    pend = bus.rd_en;
    @(posedge clk);
    #1;
    chk("rd_valid", {31'd0, bus.rd_valid}, {31'd0, pend});
    if (pend) begin
      if (exp_q.size() == 0) chk("scoreboard_empty", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("delta3_out", bus.delta3_out, e);
      end
    end
    $display("step t=%0t full=%0d rd_valid=%0d dout=%0d scost=%0h ecost=%0h cnt=%0d sat=%0d drop=%0d",
             $time, bus.full, bus.rd_valid, $signed(bus.delta3_out), bus.sample_cost,
             bus.epoch_cost, bus.sample_cnt, bus.sat, bus.drop);
    bus.in_valid  = 1'b0;
    bus.rd_en     = 1'b0;
    bus.rd_done   = 1'b0;
    bus.clr_epoch = 1'b0;
  endtask

  task automatic chk_status(input string tag, input logic f, input logic [31:0] sc,
                            input logic [31:0] ec, input logic [31:0] cnt,
                            input logic s, input logic dr);
    chk({tag, "_full"}, {31'd0, bus.full}, {31'd0, f});
    chk({tag, "_sample_cost"}, bus.sample_cost, sc);
    chk({tag, "_epoch_cost"}, bus.epoch_cost, ec);
    chk({tag, "_sample_cnt"}, {16'd0, bus.sample_cnt}, cnt);
    chk({tag, "_sat"}, {31'd0, bus.sat}, {31'd0, s});
    chk({tag, "_drop"}, {31'd0, bus.drop}, {31'd0, dr});
  endtask

  initial begin
    bus.in_valid = 0; bus.delta3_in = 0; bus.cost_in = 0; bus.rd_en = 0;
    bus.rd_addr = 0; bus.rd_done = 0; bus.clr_epoch = 0;
    rst_n = 1'b0;
    step(); step();
    chk_status("reset", 0, 0, 0, 0, 0, 0);
    chk("reset_dout", bus.delta3_out, 0);
    rst_n = 1'b1;

    // Sample 1
    beat(10, 1);  step();
    beat(-20, 2); step();
    beat(30, 3);  step();
    chk("not_full_early", {31'd0, bus.full}, 0);
    beat(-40, 4); step();
    chk_status("t1", 1, 10, 10, 1, 0, 0);

    // Back-to-back reads of the held vector
    rd(0, 10);  step();
    rd(1, -20); step();
    rd(2, 30);  step();
    rd(3, -40); step();
    step();
    chk("dout_hold", bus.delta3_out, -40);

    // Write while full is dropped; buffer unchanged
    beat(99, 7); step();
    chk_status("t3_drop", 1, 10, 10, 1, 0, 1);
    rd(0, 10); step();
    bus.rd_done = 1'b1; beat(55, 9); step();
    chk_status("t3_release", 0, 10, 10, 1, 0, 1);

    // Saturating sample
    beat(1, 32'h7FFF_FFF0); step();
    beat(2, 32'h0000_0020); step();
    beat(3, 0); step();
    beat(4, 0); step();
    chk_status("t4_sat", 1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 2, 1, 1);
    rd(0, 1); step();
    rd(3, 4); step();
    bus.rd_done = 1'b1; step();
    bus.clr_epoch = 1'b1; step();
    chk_status("t4_clr", 0, 32'h7FFF_FFFF, 0, 0, 0, 0);

    // clr_epoch with the last beat; read-during-write returns old value
    beat(7, 1); rd(0, 1); step();
    beat(8, 1); step();
    beat(9, 1); step();
    beat(10, 2); bus.clr_epoch = 1'b1; step();
    chk_status("t5_clr_last", 1, 5, 5, 1, 0, 0);
    rd(0, 7); step();
    bus.rd_done = 1'b1; step();

    // Reset mid-sample
    beat(11, 1); step();
    beat(12, 1); step();
    rst_n = 1'b0; step();
    chk_status("t5_reset", 0, 0, 0, 0, 0, 0);
    chk("t5_reset_dout", bus.delta3_out, 0);
    rst_n = 1'b1;
    beat(21, 1); step();
    beat(22, 1); step();
    beat(23, 1); step();
    beat(24, 1); step();
    chk_status("t5_after", 1, 4, 4, 1, 0, 0);
    rd(0, 21); step();
    rd(1, 22); step();
    rd(3, 24); step();
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
